// File: rtl/rf_write_scheduler.sv
// Shares the register_file write port between the writeback stage and a buffered long-latency unit,
// with a scoreboard of registers awaiting LU results. Optional bypass ports under RF_WR_BYPASS_EN.
module rf_write_scheduler #(
  parameter int FIFO_DEPTH      = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DATA_WIDTH      = 32
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_issue_valid,
  input  logic [4:0]            i_issue_rd,
  output logic                  o_issue_ready,
  input  logic                  i_wb_valid,
  input  logic [4:0]            i_wb_rd,
  input  logic [DATA_WIDTH-1:0] i_wb_data,
  output logic                  o_wb_stall,
  input  logic                  i_lu_valid,
  input  logic [4:0]            i_lu_rd,
  input  logic [DATA_WIDTH-1:0] i_lu_data,
  output logic                  o_lu_ready,
  input  logic [4:0]            i_addr_rs1,
  input  logic [4:0]            i_addr_rs2,
  output logic                  o_rs1_pending,
  output logic                  o_rs2_pending,
`ifdef RF_WR_BYPASS_EN
  output logic                  o_rs1_byp_valid,
  output logic                  o_rs2_byp_valid,
  output logic [DATA_WIDTH-1:0] o_rs1_byp_data,
  output logic [DATA_WIDTH-1:0] o_rs2_byp_data,
`endif
  output logic                  o_rf_write_enable,
  output logic [4:0]            o_rf_addr_rd,
  output logic [DATA_WIDTH-1:0] o_rf_data_rd
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = 4;

  logic [4:0]            r_fifo_rd   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [31:0]           r_pending;
  logic [OUT_W-1:0]      r_outstanding;
  logic                  r_rf_we;
  logic [4:0]            r_rf_addr;
  logic [DATA_WIDTH-1:0] r_rf_data;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_grant_fifo;
  logic                  w_grant_wb;
  logic                  w_grant_any;
  logic [4:0]            w_grant_rd;
  logic [DATA_WIDTH-1:0] w_grant_data;
  logic                  w_push;
  logic                  w_issue_acc;
  logic [4:0]            w_head_rd;
  logic [PTR_W-1:0]      w_wr_ptr_nxt;
  logic [PTR_W-1:0]      w_rd_ptr_nxt;
  logic                  w_rs1_pend_raw;
  logic                  w_rs2_pend_raw;

  assign w_fifo_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign w_head_rd    = r_fifo_rd[r_rd_ptr];

  // Full FIFO outranks WB so the LU can never be blocked indefinitely behind a busy pipeline.
  assign w_grant_fifo = w_fifo_full || (!i_wb_valid && !w_fifo_empty);
  assign w_grant_wb   = !w_fifo_full && i_wb_valid;
  assign w_grant_any  = w_grant_fifo || w_grant_wb;
  assign w_grant_rd   = w_grant_fifo ? w_head_rd : i_wb_rd;
  assign w_grant_data = w_grant_fifo ? r_fifo_data[r_rd_ptr] : i_wb_data;

  assign o_wb_stall   = w_fifo_full && i_wb_valid;
  assign o_lu_ready   = !w_fifo_full;
  assign w_push       = i_lu_valid && !w_fifo_full;

  assign o_issue_ready = (r_outstanding < OUT_W'(MAX_OUTSTANDING)) && !r_pending[i_issue_rd];
  assign w_issue_acc   = i_issue_valid && o_issue_ready;

  assign w_wr_ptr_nxt = (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
  assign w_rd_ptr_nxt = (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

  assign w_rs1_pend_raw = r_pending[i_addr_rs1];
  assign w_rs2_pend_raw = r_pending[i_addr_rs2];

`ifdef RF_WR_BYPASS_EN
  assign o_rs1_byp_valid = w_grant_any && (w_grant_rd == i_addr_rs1) && (i_addr_rs1 != 5'd0);
  assign o_rs2_byp_valid = w_grant_any && (w_grant_rd == i_addr_rs2) && (i_addr_rs2 != 5'd0);
  assign o_rs1_byp_data  = w_grant_data;
  assign o_rs2_byp_data  = w_grant_data;
  assign o_rs1_pending   = w_rs1_pend_raw && !o_rs1_byp_valid;
  assign o_rs2_pending   = w_rs2_pend_raw && !o_rs2_byp_valid;
`else
  assign o_rs1_pending   = w_rs1_pend_raw;
  assign o_rs2_pending   = w_rs2_pend_raw;
`endif

  assign o_rf_write_enable = r_rf_we;
  assign o_rf_addr_rd      = r_rf_addr;
  assign o_rf_data_rd      = r_rf_data;

  // Storage needs no reset: the count and pointers alone define which entries are live.
  always_ff @(posedge i_clock) begin
    if (w_push) begin
      r_fifo_rd[r_wr_ptr]   <= i_lu_rd;
      r_fifo_data[r_wr_ptr] <= i_lu_data;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= w_wr_ptr_nxt;
      if (w_grant_fifo)
        r_rd_ptr <= w_rd_ptr_nxt;
      if (w_push && !w_grant_fifo)
        r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_grant_fifo)
        r_count <= r_count - CNT_W'(1);
    end
  end

  // Clear before set, so a re-issue to the register being retired this cycle keeps its bit.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pending     <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_grant_fifo)
        r_pending[w_head_rd] <= 1'b0;
      if (w_issue_acc && (i_issue_rd != 5'd0))
        r_pending[i_issue_rd] <= 1'b1;
      r_pending[0] <= 1'b0;
      if (w_issue_acc && !w_grant_fifo)
        r_outstanding <= r_outstanding + OUT_W'(1);
      else if (!w_issue_acc && w_grant_fifo && (r_outstanding != '0))
        r_outstanding <= r_outstanding - OUT_W'(1);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_rf_we   <= 1'b0;
      r_rf_addr <= '0;
      r_rf_data <= '0;
    end else begin
      r_rf_we <= w_grant_any && (w_grant_rd != 5'd0);
      if (w_grant_any) begin
        r_rf_addr <= w_grant_rd;
        r_rf_data <= w_grant_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler (default build, FIFO_DEPTH=2, MAX_OUTSTANDING=4).
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_stall;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic [4:0]  addr_rs1;
  logic [4:0]  addr_rs2;
  logic        rs1_pending;
  logic        rs2_pending;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rf_write_scheduler #(.FIFO_DEPTH(2), .MAX_OUTSTANDING(4), .DATA_WIDTH(32)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd), .o_issue_ready(issue_ready),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data), .o_wb_stall(wb_stall),
    .i_lu_valid(lu_valid), .i_lu_rd(lu_rd), .i_lu_data(lu_data), .o_lu_ready(lu_ready),
    .i_addr_rs1(addr_rs1), .i_addr_rs2(addr_rs2),
    .o_rs1_pending(rs1_pending), .o_rs2_pending(rs2_pending),
    .o_rf_write_enable(rf_we), .o_rf_addr_rd(rf_addr), .o_rf_data_rd(rf_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
    chk({tag, "_we"}, {31'd0, rf_we}, {31'd0, we});
    chk({tag, "_addr"}, {27'd0, rf_addr}, {27'd0, a});
    chk({tag, "_data"}, rf_data, d);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_rd = 5'd0;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
    addr_rs1 = 5'd0; addr_rs2 = 5'd0;

    // Reset state
    #2;
    chk_rf("rst", 1'b0, 5'd0, 32'd0);
    chk("rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    chk("rst_wb_stall", {31'd0, wb_stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Single LU op to x5, result three cycles after issue
    issue_valid = 1'b1; issue_rd = 5'd5;
    settle();
    chk("iss5_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_valid = 1'b0; addr_rs1 = 5'd5;
    settle();
    chk("x5_pend_c1", {31'd0, rs1_pending}, 32'd1);
    tick();
    chk("x5_pend_c2", {31'd0, rs1_pending}, 32'd1);
    tick();
    chk("x5_pend_c3", {31'd0, rs1_pending}, 32'd1);
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEAD_BEEF;
    settle();
    chk("lu5_ready", {31'd0, lu_ready}, 32'd1);
    chk("lu5_we_pre", {31'd0, rf_we}, 32'd0);
    tick();
    lu_valid = 1'b0;
    settle();
    chk("x5_pend_grant", {31'd0, rs1_pending}, 32'd1);
    chk("lu5_we_grant", {31'd0, rf_we}, 32'd0);
    tick();
    chk_rf("lu5_write", 1'b1, 5'd5, 32'hDEAD_BEEF);
    chk("x5_pend_clr", {31'd0, rs1_pending}, 32'd0);
    tick();
    chk("lu5_we_once", {31'd0, rf_we}, 32'd0);

    // WB every cycle while LU fills the FIFO
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_rd = 5'd4;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd10; wb_data = 32'h0000_00A0;
    lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h0000_0333;
    settle();
    chk("c0_stall", {31'd0, wb_stall}, 32'd0);
    chk("c0_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    chk_rf("c0_wb", 1'b1, 5'd10, 32'h0000_00A0);
    wb_rd = 5'd11; wb_data = 32'h0000_00B1;
    lu_rd = 5'd4; lu_data = 32'h0000_0444;
    settle();
    chk("c1_stall", {31'd0, wb_stall}, 32'd0);
    chk("c1_lu_ready", {31'd0, lu_ready}, 32'd1);
    tick();
    chk_rf("c1_wb", 1'b1, 5'd11, 32'h0000_00B1);
    wb_rd = 5'd12; wb_data = 32'h0000_00C2;
    lu_valid = 1'b0;
    settle();
    chk("c2_lu_ready_full", {31'd0, lu_ready}, 32'd0);
    chk("c2_stall", {31'd0, wb_stall}, 32'd1);
    tick();
    chk_rf("c2_head3", 1'b1, 5'd3, 32'h0000_0333);
    addr_rs1 = 5'd3; addr_rs2 = 5'd4;
    settle();
    chk("c3_stall", {31'd0, wb_stall}, 32'd0);
    chk("c3_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("c3_x3_pend", {31'd0, rs1_pending}, 32'd0);
    chk("c3_x4_pend", {31'd0, rs2_pending}, 32'd1);
    tick();
    chk_rf("c3_held_wb", 1'b1, 5'd12, 32'h0000_00C2);
    wb_valid = 1'b0;
    tick();
    chk_rf("c4_head4", 1'b1, 5'd4, 32'h0000_0444);
    chk("c4_x4_pend", {31'd0, rs2_pending}, 32'd0);
    tick();
    chk("c5_we_idle", {31'd0, rf_we}, 32'd0);

    // WAW on x7 and outstanding limit
    issue_valid = 1'b1; issue_rd = 5'd7;
    settle();
    chk("x7_first_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    chk("x7_waw_ready", {31'd0, issue_ready}, 32'd0);
    tick();
    issue_rd = 5'd8;
    settle();
    chk("x8_ready", {31'd0, issue_ready}, 32'd1);
    tick();
    issue_rd = 5'd9;
    tick();
    issue_rd = 5'd10;
    tick();
    issue_rd = 5'd11;
    settle();
    chk("limit_x11_ready", {31'd0, issue_ready}, 32'd0);
    issue_rd = 5'd0;
    settle();
    chk("limit_x0_ready", {31'd0, issue_ready}, 32'd0);
    issue_valid = 1'b0;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_0777;
    tick();
    lu_valid = 1'b0;
    tick();
    chk_rf("lu7_write", 1'b1, 5'd7, 32'h0000_0777);
    issue_rd = 5'd7;
    settle();
    chk("x7_reissue_ready", {31'd0, issue_ready}, 32'd1);

    // WB to x0 is consumed without a write
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h0000_1234;
    settle();
    chk("x0_stall", {31'd0, wb_stall}, 32'd0);
    tick();
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    wb_valid = 1'b0;
    tick();

    // Reset with a full FIFO and x5 pending
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0000_0011;
    lu_valid = 1'b1; lu_rd = 5'd8; lu_data = 32'h0000_0888;
    tick();
    wb_rd = 5'd2; wb_data = 32'h0000_0022;
    lu_rd = 5'd9; lu_data = 32'h0000_0999;
    tick();
    lu_valid = 1'b0;
    addr_rs1 = 5'd5; addr_rs2 = 5'd9;
    settle();
    chk("pre_rst_lu_ready", {31'd0, lu_ready}, 32'd0);
    chk("pre_rst_x5_pend", {31'd0, rs1_pending}, 32'd1);
    rst = 1'b1;
    settle();
    chk_rf("mid_rst", 1'b0, 5'd0, 32'd0);
    chk("mid_rst_lu_ready", {31'd0, lu_ready}, 32'd1);
    chk("mid_rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("mid_rst_rs1_pend", {31'd0, rs1_pending}, 32'd0);
    chk("mid_rst_rs2_pend", {31'd0, rs2_pending}, 32'd0);
    chk("mid_rst_issue_ready", {31'd0, issue_ready}, 32'd1);
    wb_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    chk("post_rst_we", {31'd0, rf_we}, 32'd0);
    chk("post_rst_lu_ready", {31'd0, lu_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
